// File: rtl/hazard_irq_ctrl.sv
// hazard_irq_ctrl
// Hazard and interrupt controller sitting beside the ID stage of the 5-stage
// pipeline. Resolves control/exception redirects and multi-cycle load-use
// stalls, and injects edge-captured, maskable, lowest-index-first interrupts
// only at safe instruction boundaries.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   PC                    ID-stage PC (bit 31 = kernel mode)
//   opcode, funct         ID-stage instruction fields
//   PCSrc, Branch         PC select (1 br, 2/3 j/jr, 4 irq vec, 5 exc vec), branch taken
//   ID_Rs, ID_Rt          ID source registers
//   ID_ALUSrc1/2          0 = operand comes from Rs/Rt
//   EX_Rt, EX_MemRd       EX destination register, EX is a load
//   ID_NoIRQ              ID instruction tagged non-interruptible
//   irq_in, irq_mask      interrupt lines (sync to clk), channel enables
//   IF_ID_Src             0 normal, 1 flush, 2 hold
//   IF_NoIRQ              tag instruction entering ID as non-interruptible
//   ID_EX_Stall, PCHold   bubble into EX, freeze PC
//   IRQ_take, IRQ_id      one-cycle interrupt take pulse and winning channel
//   irq_pending           pending interrupt status
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | normal flow; load-use comparator active; interrupts may be taken
// LU_STALL | remaining cycles of a multi-cycle load-use stall (cnt counts down)
// IRQ_WAIT | interrupt taken, waiting for the vector redirect (PCSrc 4/5)

module hazard_irq_ctrl #(
  parameter int N_IRQ    = 4,
  parameter int LOAD_LAT = 1,
  parameter int IDW      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PC,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [2:0]       PCSrc,
  input  logic             Branch,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_ALUSrc1,
  input  logic             ID_ALUSrc2,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_MemRd,
  input  logic             ID_NoIRQ,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_mask,
  output logic [1:0]       IF_ID_Src,
  output logic             IF_NoIRQ,
  output logic             ID_EX_Stall,
  output logic             PCHold,
  output logic             IRQ_take,
  output logic [IDW-1:0]   IRQ_id,
  output logic [N_IRQ-1:0] irq_pending
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    IRQ_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

  state_t           state, state_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic [N_IRQ-1:0] pending, pending_nxt;
  logic [N_IRQ-1:0] irq_prev;
  // Cleared by reset so that the first sample after release only primes
  // irq_prev; a line already high at release is not treated as an edge.
  logic             armed;

  logic             exc_redirect;
  logic             ctl_redirect;
  logic             lu_cmp;
  logic             lu_detect;
  logic             ctl_op;
  logic             safe_point;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] take_vec;
  logic [N_IRQ-1:0] rise;
  logic [IDW-1:0]   take_id;
  logic             take;

  logic unused_pc;
  assign unused_pc = ^PC[30:0];

  assign irq_pending = pending;

  always_comb begin
    exc_redirect = (PCSrc == 3'd4) || (PCSrc == 3'd5);
    ctl_redirect = (PCSrc == 3'd2) || (PCSrc == 3'd3) || ((PCSrc == 3'd1) && Branch);
    lu_cmp = EX_MemRd && ((!ID_ALUSrc1 && (ID_Rs == EX_Rt)) ||
                          (!ID_ALUSrc2 && (ID_Rt == EX_Rt)));
    lu_detect = (state == IDLE) && lu_cmp;

    ctl_op = ((opcode >= 6'h01) && (opcode <= 6'h07)) ||
             ((opcode == 6'h00) && ((funct == 6'h08) || (funct == 6'h09)));
    safe_point = !PC[31] && !ID_NoIRQ && !ctl_op;

    eligible = pending & irq_mask;
    // Isolate the lowest set bit: that channel wins.
    take_vec = eligible & (~eligible + N_IRQ'(1));
    take_id  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) take_id = IDW'(i);
    end

    take = !reset && (state == IDLE) && safe_point && (|eligible) &&
           !exc_redirect && !ctl_redirect && !lu_cmp;
    if (!take) take_vec = '0;

    rise = irq_in & ~irq_prev & {N_IRQ{armed}};
    // A new edge wins over a same-cycle clear.
    pending_nxt = (pending & ~take_vec) | rise;
  end

  always_comb begin
    IF_ID_Src   = 2'd0;
    IF_NoIRQ    = 1'b0;
    ID_EX_Stall = 1'b0;
    PCHold      = 1'b0;
    IRQ_take    = take;
    IRQ_id      = take ? take_id : '0;
    if (!reset) begin
      if (exc_redirect) begin
        IF_ID_Src = 2'd1;
      end else if ((state == LU_STALL) || lu_detect) begin
        IF_ID_Src   = 2'd2;
        ID_EX_Stall = 1'b1;
        PCHold      = 1'b1;
      end else if (ctl_redirect) begin
        IF_ID_Src = 2'd1;
        IF_NoIRQ  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (exc_redirect) begin
          state_nxt = IDLE;
        end else if (lu_detect && (LOAD_LAT > 1)) begin
          state_nxt = LU_STALL;
          cnt_nxt   = CNT_INIT;
        end else if (take) begin
          state_nxt = IRQ_WAIT;
        end
      end
      LU_STALL: begin
        if (exc_redirect || (cnt == 3'd0)) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      IRQ_WAIT: begin
        if (exc_redirect) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      pending  <= '0;
      irq_prev <= '0;
      armed    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pending  <= pending_nxt;
      irq_prev <= irq_in;
      armed    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_irq_ctrl.sv
module tb_hazard_irq_ctrl;
  localparam int N  = 4;
  localparam int LL = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   PC;
  logic [5:0]    opcode, funct;
  logic [2:0]    PCSrc;
  logic          Branch;
  logic [4:0]    ID_Rs, ID_Rt, EX_Rt;
  logic          ID_ALUSrc1, ID_ALUSrc2, EX_MemRd, ID_NoIRQ;
  logic [N-1:0]  irq_in, irq_mask;
  logic [1:0]    IF_ID_Src;
  logic          IF_NoIRQ, ID_EX_Stall, PCHold, IRQ_take;
  logic [IW-1:0] IRQ_id;
  logic [N-1:0]  irq_pending;

  int vectors = 0;
  int miscompares = 0;

  hazard_irq_ctrl #(.N_IRQ(N), .LOAD_LAT(LL)) dut (
    .clk(clk), .reset(reset), .PC(PC), .opcode(opcode), .funct(funct),
    .PCSrc(PCSrc), .Branch(Branch), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_ALUSrc1(ID_ALUSrc1), .ID_ALUSrc2(ID_ALUSrc2), .EX_Rt(EX_Rt),
    .EX_MemRd(EX_MemRd), .ID_NoIRQ(ID_NoIRQ), .irq_in(irq_in),
    .irq_mask(irq_mask), .IF_ID_Src(IF_ID_Src), .IF_NoIRQ(IF_NoIRQ),
    .ID_EX_Stall(ID_EX_Stall), .PCHold(PCHold), .IRQ_take(IRQ_take),
    .IRQ_id(IRQ_id), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining stall cycles, waiting-for-vector flag,
  // pending bit vector and the last sampled irq lines.
  int           m_stall = 0, n_stall = 0;
  bit           m_wait = 0, n_wait = 0;
  logic [N-1:0] m_pend = '0, n_pend = '0;
  logic [N-1:0] m_prev = '0, n_prev = '0;
  bit           m_prev_ok = 0, n_prev_ok = 0;

  always @(negedge clk) begin : compare
    logic [1:0]   e_src;
    logic         e_noirq, e_stall, e_hold, e_take;
    logic [IW-1:0] e_id;
    logic [N-1:0] elig;
    bit exc, ctl, cmp, stalling, lu, safe;
    e_src = 0; e_noirq = 0; e_stall = 0; e_hold = 0; e_take = 0; e_id = 0;
    if (reset) begin
      n_stall = 0; n_wait = 0; n_pend = '0; n_prev = '0; n_prev_ok = 0;
      chk("pend_rst", irq_pending, 0);
    end else begin
      exc = (PCSrc == 4) || (PCSrc == 5);
      ctl = (PCSrc == 2) || (PCSrc == 3) || (PCSrc == 1 && Branch);
      cmp = EX_MemRd && ((!ID_ALUSrc1 && ID_Rs == EX_Rt) || (!ID_ALUSrc2 && ID_Rt == EX_Rt));
      stalling = m_stall > 0;
      lu = !m_wait && !stalling && cmp;
      if (exc) e_src = 1;
      else if (stalling || lu) begin e_src = 2; e_stall = 1; e_hold = 1; end
      else if (ctl) begin e_src = 1; e_noirq = 1; end
      safe = !PC[31] && !ID_NoIRQ && !(opcode >= 1 && opcode <= 7) &&
             !(opcode == 0 && (funct == 8 || funct == 9));
      elig = m_pend & irq_mask;
      e_take = !m_wait && !stalling && safe && (elig != 0) && !exc && !ctl && !cmp;
      if (e_take) for (int i = N - 1; i >= 0; i--) if (elig[i]) e_id = IW'(i);
      n_stall = exc ? 0 : (stalling ? m_stall - 1 : (lu ? LL - 1 : 0));
      n_wait  = exc ? 0 : (m_wait || e_take);
      n_pend  = m_pend;
      if (e_take) n_pend[e_id] = 1'b0;
      if (m_prev_ok) n_pend = n_pend | (irq_in & ~m_prev);
      n_prev = irq_in;
      n_prev_ok = 1;
      chk("pending", irq_pending, m_pend);
    end
    chk("if_id_src", IF_ID_Src, e_src);
    chk("if_noirq", IF_NoIRQ, e_noirq);
    chk("id_ex_stall", ID_EX_Stall, e_stall);
    chk("pchold", PCHold, e_hold);
    chk("irq_take", IRQ_take, e_take);
    chk("irq_id", IRQ_id, e_id);
  end

  always @(posedge clk) begin
    m_stall = n_stall; m_wait = n_wait; m_pend = n_pend;
    m_prev = n_prev; m_prev_ok = n_prev_ok;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    PC = 0; opcode = 0; funct = 6'h20; PCSrc = 0; Branch = 0;
    ID_Rs = 0; ID_Rt = 0; ID_ALUSrc1 = 1; ID_ALUSrc2 = 1;
    EX_Rt = 0; EX_MemRd = 0; ID_NoIRQ = 0;
  endtask

  task automatic set_lu();
    EX_MemRd = 1; EX_Rt = 5; ID_Rs = 5; ID_ALUSrc1 = 0;
  endtask

  task automatic clr_lu();
    EX_MemRd = 0; EX_Rt = 0; ID_Rs = 0; ID_ALUSrc1 = 1;
  endtask

  logic [5:0] ops [6];

  initial begin
    ops = '{6'h00, 6'h00, 6'h01, 6'h04, 6'h23, 6'h02};
    reset = 1; defaults(); irq_in = 0; irq_mask = 0;
    #3;
    chk("rst_src", IF_ID_Src, 0); chk("rst_take", IRQ_take, 0);
    chk("rst_pend", irq_pending, 0);
    repeat (2) tick();
    reset = 0;

    // load-use stall of exactly LOAD_LAT cycles
    tick(); set_lu(); #2;
    chk("lu_src0", IF_ID_Src, 2); chk("lu_hold0", PCHold, 1); chk("lu_stall0", ID_EX_Stall, 1);
    tick(); clr_lu(); #2;
    chk("lu_hold1", PCHold, 1); chk("lu_src1", IF_ID_Src, 2);
    tick(); #2;
    chk("lu_hold2", PCHold, 1); chk("lu_stall2", ID_EX_Stall, 1);
    tick(); #2;
    chk("lu_hold3", PCHold, 0); chk("lu_src3", IF_ID_Src, 0);

    // exception beats load-use
    tick(); set_lu(); PCSrc = 5; #2;
    chk("exc_src", IF_ID_Src, 1); chk("exc_hold", PCHold, 0); chk("exc_stall", ID_EX_Stall, 0);
    tick(); clr_lu(); PCSrc = 0; #2;
    chk("exc_after", PCHold, 0);

    // irq vector aborts LU_STALL
    tick(); set_lu(); #2; chk("ab_hold0", PCHold, 1);
    tick(); clr_lu(); PCSrc = 4; #2;
    chk("ab_src", IF_ID_Src, 1); chk("ab_hold1", PCHold, 0);
    tick(); PCSrc = 0; #2;
    chk("ab_hold2", PCHold, 0); chk("ab_src2", IF_ID_Src, 0);

    // two simultaneous edges, lowest index first
    irq_mask = 4'b1111;
    tick(); irq_in = 4'b0110; #2; chk("i_take0", IRQ_take, 0);
    tick(); #2;
    chk("i_take1", IRQ_take, 1); chk("i_id1", IRQ_id, 1); chk("i_pend1", irq_pending, 4'b0110);
    tick(); #2; chk("i_wait", IRQ_take, 0); chk("i_pend2", irq_pending, 4'b0100);
    tick(); PCSrc = 4; #2; chk("i_vec", IRQ_take, 0);
    tick(); PCSrc = 0; #2; chk("i_take2", IRQ_take, 1); chk("i_id2", IRQ_id, 2);
    tick(); PCSrc = 4; irq_in = 0; #2; chk("i_pend3", irq_pending, 0);
    tick(); PCSrc = 0;

    // unsafe points hold off the take
    tick(); opcode = 6'h04; irq_in = 4'b0001;
    tick(); #2; chk("s_beq", IRQ_take, 0); chk("s_pend", irq_pending, 4'b0001);
    tick(); opcode = 0; funct = 6'h20; PC = 32'h8000_0000; #2; chk("s_kern", IRQ_take, 0);
    tick(); PC = 0; #2; chk("s_take", IRQ_take, 1); chk("s_id", IRQ_id, 0);
    tick(); PCSrc = 4; irq_in = 0;
    tick(); PCSrc = 0;

    // masked channel still latches
    tick(); irq_mask = 4'b0111; irq_in = 4'b1000;
    tick(); #2; chk("m_pend", irq_pending, 4'b1000); chk("m_take0", IRQ_take, 0);
    tick(); irq_mask = 4'b1111; #2; chk("m_take1", IRQ_take, 1); chk("m_id", IRQ_id, 3);
    tick(); PCSrc = 4; irq_in = 0;
    tick(); PCSrc = 0;

    // reset in LU_STALL with a pending masked channel
    tick(); irq_mask = 0; irq_in = 4'b1000;
    tick(); set_lu(); #2; chk("r_pend", irq_pending, 4'b1000); chk("r_hold0", PCHold, 1);
    tick(); clr_lu(); #2; chk("r_hold1", PCHold, 1);
    reset = 1; #1;
    chk("r_hold2", PCHold, 0); chk("r_src", IF_ID_Src, 0); chk("r_stall", ID_EX_Stall, 0);
    chk("r_pend0", irq_pending, 0);
    tick(); tick(); reset = 0; irq_mask = 4'b1111;
    repeat (6) begin
      tick(); #2; chk("r_notake", IRQ_take, 0); chk("r_nopend", irq_pending, 0);
    end
    tick(); irq_in = 0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      tick();
      reset = ($urandom_range(0, 299) == 0);
      PC = {($urandom_range(0, 7) == 0), 31'($urandom)};
      opcode = ops[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0: funct = 6'h08;
        1: funct = 6'h09;
        2: funct = 6'h20;
        default: funct = 6'h21;
      endcase
      r = $urandom_range(0, 15);
      PCSrc = (r < 11) ? 3'd0 : 3'(r - 10);
      Branch = 1'($urandom);
      ID_Rs = 5'($urandom_range(0, 3));
      ID_Rt = 5'($urandom_range(0, 3));
      EX_Rt = 5'($urandom_range(0, 3));
      ID_ALUSrc1 = 1'($urandom);
      ID_ALUSrc2 = 1'($urandom);
      EX_MemRd = ($urandom_range(0, 2) == 0);
      ID_NoIRQ = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom);
    end
    tick(); reset = 0; defaults();
    tick(); #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hazard_irq_ctrl.md
# hazard_irq_ctrl

Parametrised hazard and interrupt controller for the 5-stage pipeline, successor to the single-cycle-latency combinational hazard unit. Sits beside the ID stage. It drives IF/ID source select, ID/EX bubble, PC hold and IF no-interrupt tagging. It adds a multi-cycle load-use stall counter for slow data memory, and an N-channel edge-captured, maskable, prioritised interrupt front end. That front end only injects an interrupt at a safe point.

## Interface
Parameters:
- N_IRQ, 4: number of external interrupt channels (1..16).
- LOAD_LAT, 1: data-memory read latency in cycles; load-use stall length (1..8).
- IDW, max(1,$clog2(N_IRQ)): width of IRQ_id.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- PC  in  32  ID-stage PC; PC[31]=1 means kernel mode.
- opcode, funct  in  6 each  ID-stage instruction fields.
- PCSrc  in  3  PC select: 1 branch, 2/3 jump/jr, 4 interrupt vector, 5 exception vector.
- Branch  in  1  branch condition true.
- ID_Rs, ID_Rt  in  5 each  ID source registers.
- ID_ALUSrc1, ID_ALUSrc2  in  1 each  0 = operand read from Rs/Rt.
- EX_Rt  in  5  EX destination register.
- EX_MemRd  in  1  EX instruction is a load.
- ID_NoIRQ  in  1  ID instruction is tagged non-interruptible.
- irq_in  in  N_IRQ  level interrupt lines, synchronous to clk.
- irq_mask  in  N_IRQ  1 = channel enabled.
- IF_ID_Src  out  2  0 normal, 1 flush (bubble), 2 hold.
- IF_NoIRQ  out  1  tag the instruction entering ID as non-interruptible.
- ID_EX_Stall  out  1  insert bubble into EX.
- PCHold  out  1  freeze PC.
- IRQ_take  out  1  one-cycle pulse: datapath selects interrupt vector next cycle.
- IRQ_id  out  IDW  channel being taken; valid while IRQ_take=1, else 0.
- irq_pending  out  N_IRQ  pending register (status).

## Operation
- Pending capture: irq_prev registers irq_in. pending[i] sets on a rising edge of irq_in[i] and clears when channel i is taken. A set and a clear in the same cycle leave the bit set. Masked channels still latch.
- Hazard priority, highest first:
  - PCSrc 4/5: IF_ID_Src=1, other outputs 0; aborts any load-use stall (state→IDLE, counter→0).
  - Load-use: EX_MemRd and ((!ID_ALUSrc1 and ID_Rs==EX_Rt) or (!ID_ALUSrc2 and ID_Rt==EX_Rt)). Outputs IF_ID_Src=2, ID_EX_Stall=1, PCHold=1.
  - PCSrc 2/3, or PCSrc 1 with Branch: IF_ID_Src=1, IF_NoIRQ=1.
  - Otherwise all 0.
- Load-use detection uses only the comparator in IDLE.
- FSM states:
  - IDLE: on load-use detect with LOAD_LAT>1, go to LU_STALL with cnt=LOAD_LAT-2. With LOAD_LAT=1, stay in IDLE.
  - LU_STALL: drive load-use outputs unconditionally, ignoring the EX fields. Decrement cnt each cycle; at cnt==0 return to IDLE.
  - IRQ_WAIT: entered after IRQ_take. Blocks further takes. Returns to IDLE when PCSrc==4 or PCSrc==5.
- Safe point: PC[31]=0, ID_NoIRQ=0, and the ID opcode is none of the following:
  - 0x01, 0x02–0x07;
  - opcode 0 with funct 0x08/0x09.
- IRQ take conditions, all required:
  - state IDLE;
  - safe point;
  - (pending & irq_mask) != 0;
  - no PCSrc 1–5 hazard this cycle;
  - no load-use detect this cycle.
- On take, the lowest-index pending enabled channel wins. IRQ_take=1 and IRQ_id=index; the bit clears next edge; state→IRQ_WAIT.

## Timing
- Hazard outputs are combinational from inputs and state, with zero-cycle latency.
- Load-use total stall = LOAD_LAT cycles: the detect cycle plus LOAD_LAT-1 LU_STALL cycles.
- irq_in edge at edge k: pending visible after edge k+1. The earliest IRQ_take is in the cycle after that edge.
- IRQ_take is never asserted in two consecutive cycles.
- Reset: pending=0, irq_prev=0, state=IDLE, cnt=0. All outputs 0 while reset is held, since the combinational paths are gated by reset. A reset in mid-stall or in IRQ_WAIT returns to IDLE immediately.
- irq_in already high at reset release creates no pending, because no edge is seen.

## Test plan
- LOAD_LAT=3: EX_MemRd=1, EX_Rt=ID_Rs=5, ID_ALUSrc1=0 for 1 cycle, then EX fields cleared → PCHold/ID_EX_Stall=1 and IF_ID_Src=2 for exactly 3 cycles, then 0.
- Load-use and PCSrc=5 in the same cycle → IF_ID_Src=1, PCHold=0, ID_EX_Stall=0. In LU_STALL with PCSrc=4 → stall ends that cycle.
- irq_in=4'b0110 rising together, mask=4'b1111, safe point → IRQ_take with IRQ_id=1. pending becomes 4'b0100. After PCSrc=4 → next take has IRQ_id=2.
- Pending channel 0, ID opcode=0x04 (beq) or PC=0x8000_0000 → no IRQ_take. Next cycle opcode=0x00/funct=0x20 with PC[31]=0 → IRQ_take=1, IRQ_id=0.
- Masked channel: irq_in[3] edge with mask[3]=0 → pending[3]=1, no take. Setting mask[3]=1 → take with IRQ_id=3.
- Assert reset during LU_STALL with pending=4'b1000 → all outputs 0 and irq_pending=0 immediately. After release, no IRQ_take while irq_in stays high.
